// File: rtl/video_timing_pkg.sv
// Shared timing defaults, FSM encoding and pattern codes
// for the video sync generator.
package video_timing_pkg;

  localparam int H_ACTIVE_720P = 1280;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;
  localparam int H_FP_720P     = 110;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;
  localparam int V_FP_720P     = 5;
  localparam int CPP_DEF       = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic PAT_RAMP = 1'b0;
  localparam logic PAT_LINE = 1'b1;

endpackage

// File: rtl/video_sync_gen_if.sv
// Parallel video sync bundle: vsync/hsync/data/de plus
// sof and busy status. master drives, slave observes.
interface video_sync_if;
  logic       vsync_o;
  logic       hsync_o;
  logic [7:0] data_o;
  logic       de_o;
  logic       sof_o;
  logic       busy_o;

  modport master (
    output vsync_o, hsync_o, data_o,
    output de_o, sof_o, busy_o
  );

  modport slave (
    input vsync_o, hsync_o, data_o,
    input de_o, sof_o, busy_o
  );
endinterface

// File: rtl/video_timing_counter.sv
// Pixel prescaler plus h/v raster counters.
// Ports: clk/rst, clr_i, run_i -> h_o, v_o, first_o, eof_o.
module video_timing_counter #(
  parameter int H_TOTAL     = 1650,
  parameter int V_TOTAL     = 750,
  parameter int CLK_PER_PIX = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       run_i,
  output logic [$clog2(H_TOTAL)-1:0] h_o,
  output logic [$clog2(V_TOTAL)-1:0] v_o,
  output logic                       first_o,
  output logic                       eof_o
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int PW =
    (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          tick;
  logic          h_last;
  logic          v_last;

  assign tick   = (presc_q == PW'(CLK_PER_PIX - 1));
  assign h_last = (h_q == HW'(H_TOTAL - 1));
  assign v_last = (v_q == VW'(V_TOTAL - 1));

  always_comb begin
    presc_d = presc_q;
    h_d     = h_q;
    v_d     = v_q;
    if (clr_i) begin
      presc_d = '0;
      h_d     = '0;
      v_d     = '0;
    end else if (run_i) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        if (h_last) begin
          h_d = '0;
          v_d = v_last ? '0 : v_q + VW'(1);
        end else begin
          h_d = h_q + HW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      presc_q <= presc_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  assign h_o     = h_q;
  assign v_o     = v_q;
  // first cycle of a pixel; used to make sof one clock wide
  assign first_o = (presc_q == '0);
  assign eof_o   = tick && h_last && v_last;

endmodule

// File: rtl/video_sync_gen.sv
// Video sync/test-pattern source: IDLE/RUN FSM, pattern
// and registered outputs. Ports: sys_clk, sys_rst, en_i,
// pattern_i, vid (master: vsync/hsync/data/de/sof/busy).
module video_sync_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE      = H_ACTIVE_720P,
  parameter int H_SYNC        = H_SYNC_720P,
  parameter int H_BACK_PORCH  = H_BP_720P,
  parameter int H_FRONT_PORCH = H_FP_720P,
  parameter int V_ACTIVE      = V_ACTIVE_720P,
  parameter int V_SYNC        = V_SYNC_720P,
  parameter int V_BACK_PORCH  = V_BP_720P,
  parameter int V_FRONT_PORCH = V_FP_720P,
  parameter int CLK_PER_PIX   = CPP_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en_i,
  input  logic        pattern_i,
  video_sync_if.master vid
);

  localparam int H_TOTAL = H_SYNC + H_BACK_PORCH
                         + H_ACTIVE + H_FRONT_PORCH;
  localparam int V_TOTAL = V_SYNC + V_BACK_PORCH
                         + V_ACTIVE + V_FRONT_PORCH;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int H_ST = H_SYNC + H_BACK_PORCH;
  localparam int V_ST = V_SYNC + V_BACK_PORCH;

  state_t        state_q, state_d;
  logic          pat_q, pat_d;
  logic          clr;
  logic          run;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          first;
  logic          eof;
  logic          hact, vact;

  logic       vsync_q, vsync_d;
  logic       hsync_q, hsync_d;
  logic [7:0] data_q, data_d;
  logic       de_q, de_d;
  logic       sof_q, sof_d;
  logic       busy_q, busy_d;

  video_timing_counter #(
    .H_TOTAL     (H_TOTAL),
    .V_TOTAL     (V_TOTAL),
    .CLK_PER_PIX (CLK_PER_PIX)
  ) u_cnt (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .clr_i   (clr),
    .run_i   (run),
    .h_o     (h_cnt),
    .v_o     (v_cnt),
    .first_o (first),
    .eof_o   (eof)
  );

  assign run = (state_q == RUN);

  // en_i only matters at a frame boundary, so a frame
  // in flight always runs to completion.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = RUN;
          clr     = 1'b1;
          pat_d   = pattern_i;
        end
      end
      RUN: begin
        if (eof) begin
          pat_d = pattern_i;
          if (!en_i) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hact = (h_cnt >= HW'(H_ST))
        && (h_cnt < HW'(H_ST + H_ACTIVE));
    vact = (v_cnt >= VW'(V_ST))
        && (v_cnt < VW'(V_ST + V_ACTIVE));
    hsync_d = run && (h_cnt < HW'(H_SYNC));
    vsync_d = run && (v_cnt < VW'(V_SYNC));
    de_d    = run && hact && vact;
    data_d  = 8'h00;
    if (de_d) begin
      data_d = (pat_q == PAT_LINE)
             ? 8'(v_cnt) - 8'(V_ST)
             : 8'(h_cnt) - 8'(H_ST);
    end
    sof_d  = run && first
          && (h_cnt == '0) && (v_cnt == '0);
    busy_d = run;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      pat_q   <= PAT_RAMP;
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
      data_q  <= 8'h00;
      de_q    <= 1'b0;
      sof_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      vsync_q <= vsync_d;
      hsync_q <= hsync_d;
      data_q  <= data_d;
      de_q    <= de_d;
      sof_q   <= sof_d;
      busy_q  <= busy_d;
    end
  end

  assign vid.vsync_o = vsync_q;
  assign vid.hsync_o = hsync_q;
  assign vid.data_o  = data_q;
  assign vid.de_o    = de_q;
  assign vid.sof_o   = sof_q;
  assign vid.busy_o  = busy_q;

endmodule

// File: tb/tb_video_sync_gen.sv
// Bench for video_sync_gen using a reduced raster so
// that whole frames fit in a short run.
module tb_video_sync_gen;

  localparam int HS  = 3;
  localparam int HBP = 4;
  localparam int HA  = 260;
  localparam int HFP = 2;
  localparam int VS  = 1;
  localparam int VBP = 2;
  localparam int VA  = 4;
  localparam int VFP = 1;
  localparam int CPP = 2;
  localparam int HT  = HS + HBP + HA + HFP;
  localparam int VT  = VS + VBP + VA + VFP;
  localparam int LINE  = HT * CPP;
  localparam int FRAME = LINE * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic pat = 1'b0;

  video_sync_if vif ();

  video_sync_gen #(
    .H_ACTIVE      (HA),
    .H_SYNC        (HS),
    .H_BACK_PORCH  (HBP),
    .H_FRONT_PORCH (HFP),
    .V_ACTIVE      (VA),
    .V_SYNC        (VS),
    .V_BACK_PORCH  (VBP),
    .V_FRONT_PORCH (VFP),
    .CLK_PER_PIX   (CPP)
  ) dut (
    .sys_clk   (clk),
    .sys_rst   (rst),
    .en_i      (en),
    .pattern_i (pat),
    .vid       (vif)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_err = 0;
  int     k     = -1;
  bit     pend  = 1'b0;
  bit     mpat  = 1'b0;
  longint cyc   = 0;
  longint sof_q[$];

  // Expected {vsync,hsync,de,sof,busy,data} for output
  // cycle kk of a frame (kk < 0 means idle).
  function automatic logic [12:0] expv(int kk, bit p);
    int pix, h, v;
    bit de;
    logic [7:0] d;
    if (kk < 0) return 13'h0;
    pix = kk / CPP;
    h   = pix % HT;
    v   = pix / HT;
    de  = (h >= HS + HBP) && (h < HS + HBP + HA)
       && (v >= VS + VBP) && (v < VS + VBP + VA);
    d = 8'h00;
    if (de) d = 8'(p ? v - VS - VBP : h - HS - HBP);
    return {v < VS, h < HS, de, kk == 0, 1'b1, d};
  endfunction

  function automatic logic [12:0] obs();
    return {vif.vsync_o, vif.hsync_o, vif.de_o,
            vif.sof_o, vif.busy_o, vif.data_o};
  endfunction

  task automatic check(string tag, logic [12:0] e);
    logic [12:0] o;
    o = obs();
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      if (n_err <= 20)
        $error("FAIL %s cyc=%0d k=%0d observed=%h expected=%h",
               tag, cyc, k, o, e);
    end
  endtask

  task automatic chk_int(string tag, longint o, longint e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // One clock: advance the frame-position model with the
  // inputs present at the edge, then compare.
  task automatic step(string tag);
    bit en_s, pat_s, rst_s;
    en_s  = en;
    pat_s = pat;
    rst_s = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_s) begin
      k    = -1;
      pend = 1'b0;
    end else if (pend) begin
      k    = 0;
      pend = 1'b0;
    end else if (k >= 0) begin
      k++;
      if (k == FRAME) begin
        if (en_s) begin
          k    = 0;
          mpat = pat_s;
        end else begin
          k = -1;
        end
      end
    end else if (en_s) begin
      pend = 1'b1;
      mpat = pat_s;
    end
    check(tag, expv(k, mpat));
    if (vif.sof_o) sof_q.push_back(cyc);
  endtask

  // Run n cycles with random pattern_i noise, settling
  // pattern_i to fin for the final cycles.
  task automatic run_n(int n, string tag, bit fin);
    for (int i = 0; i < n; i++) begin
      if (n - i <= 4) pat = fin;
      else if ($urandom_range(0, 49) == 0) pat = ~pat;
      step(tag);
    end
  endtask

  initial begin
    int drop_at;
    int rest;
    rst = 1'b1;
    en  = 1'b1;
    pat = 1'b0;
    #1;
    check("reset_state", 13'h0);
    repeat (3) step("reset_hold");

    rst = 1'b0;
    step("en_seen");
    step("first_frame");
    chk_int("sof_rise", vif.sof_o, 1);
    chk_int("vs_hs_rise", {vif.vsync_o, vif.hsync_o}, 3);

    run_n(FRAME - 1, "frame_ramp", 1'b1);
    run_n(FRAME, "frame_line", 1'b0);

    drop_at = 3 * LINE + $urandom_range(0, LINE - 1);
    run_n(drop_at, "frame3_pre", 1'b0);
    en = 1'b0;
    rest = FRAME - drop_at;
    run_n(rest + 10, "frame3_drop", 1'b1);
    chk_int("busy_low", vif.busy_o, 0);
    chk_int("sof_count", sof_q.size(), 3);
    if (sof_q.size() == 3) begin
      chk_int("sof_gap1", sof_q[1] - sof_q[0], FRAME);
      chk_int("sof_gap2", sof_q[2] - sof_q[1], FRAME);
    end

    run_n($urandom_range(5, 30), "idle", 1'b1);
    en = 1'b1;
    run_n(5 * LINE + $urandom_range(1, LINE - 2),
          "frame_mid", 1'b0);
    #2;
    rst = 1'b1;
    #1;
    k    = -1;
    pend = 1'b0;
    check("rst_midframe", 13'h0);
    repeat (2) step("rst_hold");
    rst = 1'b0;
    sof_q.delete();
    step("restart_en");
    step("restart_frame");
    chk_int("restart_sof", vif.sof_o, 1);
    en = 1'b0;
    run_n(FRAME + 10, "last_frame", 1'b1);
    chk_int("last_sof_count", sof_q.size(), 1);
    chk_int("end_busy", vif.busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/video_sync_gen.md
Name: video_sync_gen

Overview:
- Generates the parallel video sync interface consumed by sdi2mipi: vsync, hsync, an 8-bit pixel data bus and a data-enable.
- Timing is parameterised; defaults are 1280x720p.
- Used as the on-chip stimulus source for bring-up and as the transmitter end for loopback self-test ahead of sdi2mipi.
- Produces a deterministic test pattern on the data bus so downstream fv/lv and payload checks are self-verifying.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_SYNC, 40, hsync width in pixels
- H_BACK_PORCH, 220, pixels from hsync deassert to first active pixel
- H_FRONT_PORCH, 110, pixels from last active pixel to the next hsync
- V_ACTIVE, 720, active lines per frame
- V_SYNC, 5, vsync width in lines
- V_BACK_PORCH, 20, lines from vsync deassert to first active line
- V_FRONT_PORCH, 5, lines from last active line to the next vsync
- CLK_PER_PIX, 2, sys_clk cycles per pixel (≥1)

Ports:
- sys_clk  input  1  system clock
- sys_rst  input  1  asynchronous, active-high reset
- en_i  input  1  run request; sampled only at frame boundary
- pattern_i  input  1  0 = horizontal ramp, 1 = line-number pattern
- vsync_o  output  1  vertical sync, active high
- hsync_o  output  1  horizontal sync, active high
- data_o  output  8  pixel data, 0x00 outside the active area
- de_o  output  1  active-area pixel valid
- sof_o  output  1  one sys_clk pulse on the first cycle of each frame
- busy_o  output  1  high while a frame is in progress

Behaviour:
- One clock domain: sys_clk. Reset is asynchronous and active-high (sys_rst).
- Reset state: all outputs 0; FSM in IDLE; counters 0; prescaler 0.
- Derived constants: H_TOTAL = H_SYNC+H_BACK_PORCH+H_ACTIVE+H_FRONT_PORCH (1650). V_TOTAL likewise (750).
- Counter widths: h_cnt is $clog2(H_TOTAL) bits; v_cnt is $clog2(V_TOTAL) bits.
- Prescaler counts 0..CLK_PER_PIX-1. pix_tick is high when the prescaler equals CLK_PER_PIX-1. With CLK_PER_PIX=1, pix_tick is high every cycle.
- FSM states: IDLE, RUN.
  - IDLE -> RUN: when en_i=1. h_cnt, v_cnt and the prescaler are cleared on entry.
  - RUN -> IDLE: on the pix_tick where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, if en_i=0. If en_i=1 there, stay in RUN and wrap both counters to 0.
  - Dropping en_i mid-frame never truncates the frame; the current frame always completes.
- In RUN, h_cnt increments on pix_tick and wraps at H_TOTAL-1 to 0. v_cnt increments on that wrap and wraps at V_TOTAL-1 to 0.
- Outputs are registered from the counters, one sys_clk after the counter value they reflect:
  - hsync_o = (h_cnt < H_SYNC)
  - vsync_o = (v_cnt < V_SYNC), held for whole lines
  - hact = H_SYNC+H_BACK_PORCH ≤ h_cnt < that + H_ACTIVE; vact is defined likewise on v_cnt
  - de_o = hact & vact
  - data_o: pattern_i=0 gives (h_cnt - H_SYNC - H_BACK_PORCH)[7:0]; pattern_i=1 gives (v_cnt - V_SYNC - V_BACK_PORCH)[7:0]. data_o=0x00 when de_o=0.
- pattern_i is latched at frame start; changes mid-frame take effect from the next frame.
- Ordering: hsync and vsync rise on the same cycle at frame start, with hsync leading within each line.
- busy_o = 1 in RUN. sof_o fires on the first output cycle of every frame, including back-to-back frames.
- In IDLE, all outputs are 0.
- Reset asserted mid-frame clears all outputs asynchronously. After release the block returns to IDLE and restarts at h=0, v=0 once en_i is seen.

Decomposition:
- Package video_timing_pkg holds:
  - 720p default timing localparams
  - the FSM state encoding (IDLE/RUN)
  - the pattern selection constants
- One natural sub-module: video_timing_counter. It contains the prescaler plus the h/v counters with wrap and end-of-frame flags. It is instantiated once.
- The FSM, pattern generation and output registers stay in the top module.

Test Plan:
- Reset: hold sys_rst, en_i=1 -> all outputs 0. After release, vsync_o/hsync_o/sof_o rise together on the second cycle after en_i is seen.
- Line timing, defaults: hsync_o high for 80 clocks per 3300-clock line period. de_o high for 2560 clocks starting 520 clocks after the hsync rise.
- Frame timing: vsync_o high for 5*3300 clocks; frame period 750*3300 clocks. 720 lines contain de_o, the first being line 25 after the vsync rise.
- Ramp pattern, pattern_i=0: in-line data_o sequence is 0x00,0x00,0x01,0x01…0xFF,0xFF,0x00 (wraps every 256 pixels). The last active pixel is 0xFF (1279 mod 256). data_o=0x00 during blanking.
- en_i drop at line 300 -> the frame completes to line 749 and then returns to IDLE, busy_o=0. With en_i held high, 3 consecutive frames run with sof_o pulses exactly 2 475 000 clocks apart.
- Reset mid-frame (line 400) -> outputs go to 0 in the same cycle. With en_i=1 after release, a fresh frame starts with v_cnt=0.
